// File: rtl/conv3x3_mac_relu_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg : shared widths, config addresses, FSM states, int8 saturation
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package conv_pkg;

  localparam int DATA_W = 8;
  localparam int BIAS_W = 16;
  localparam int ACC_W  = 20;
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [3:0] CFG_W0   = 4'd0;
  localparam logic [3:0] CFG_BIAS = 4'd9;
  localparam logic [3:0] CFG_CTRL = 4'd10;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    READY = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 127;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -128;

  function automatic logic signed [DATA_W-1:0] sat_int8(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] c;
    if (v > SAT_MAX) begin
      c = SAT_MAX;
    end else if (v < SAT_MIN) begin
      c = SAT_MIN;
    end else begin
      c = v;
    end
    return c[DATA_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv3x3_mac_relu_if.sv
// ---------------------------------------------------------------------------
// conv3x3_mac_relu_if : config, window and result signals of the conv stage
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface conv3x3_mac_relu_if;
  import conv_pkg::*;

  logic                     cfg_we;
  logic [3:0]               cfg_addr;
  logic [15:0]              cfg_data;
  logic [7:0]               img_width;
  logic [7:0]               img_height;
  logic                     valid_in;
  logic signed [DATA_W-1:0] win0, win1, win2, win3, win4, win5, win6, win7, win8;
  logic signed [DATA_W-1:0] pix_out;
  logic                     valid_out;
  logic                     frame_done;
  logic                     cfg_ready;
  logic                     err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, img_width, img_height, valid_in,
           win0, win1, win2, win3, win4, win5, win6, win7, win8,
    input  pix_out, valid_out, frame_done, cfg_ready, err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, img_width, img_height, valid_in,
           win0, win1, win2, win3, win4, win5, win6, win7, win8,
    output pix_out, valid_out, frame_done, cfg_ready, err
  );

endinterface

`default_nettype wire

// File: rtl/conv3x3_mac_relu_requant.sv
// ---------------------------------------------------------------------------
// conv_requant : partial-sum reduce, bias, rounding shift, ReLU, int8 saturate
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv_requant
  import conv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_in,
  input  logic signed [ACC_W-1:0]  part0,
  input  logic signed [ACC_W-1:0]  part1,
  input  logic signed [ACC_W-1:0]  part2,
  input  logic signed [BIAS_W-1:0] bias,
  input  logic [3:0]               shift,
  input  logic                     relu_en,
  output logic signed [DATA_W-1:0] pix_out,
  output logic                     valid_out
);

  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  rounded;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [ACC_W-1:0]  rectified;
  logic signed [DATA_W-1:0] pix_d, pix_q;
  logic                     valid_d, valid_q;

  always_comb begin
    sum       = part0 + part1 + part2 + ACC_W'(bias);
    rounded   = sum;
    shifted   = sum;
    if (shift != 4'd0) begin
      // Round half up before the arithmetic shift.
      rounded = sum + $signed(ACC_W'(1) << (shift - 4'd1));
      shifted = rounded >>> shift;
    end
    rectified = (relu_en && shifted[ACC_W-1]) ? '0 : shifted;
    valid_d   = valid_in;
    pix_d     = valid_in ? sat_int8(rectified) : pix_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pix_q   <= pix_d;
      valid_q <= valid_d;
    end
  end

  assign pix_out   = pix_q;
  assign valid_out = valid_q;

endmodule

`default_nettype wire

// File: rtl/conv3x3_mac_relu.sv
// ---------------------------------------------------------------------------
// conv3x3_mac_relu : 3-stage 3x3 signed conv with config regs and frame count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module conv3x3_mac_relu
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  conv3x3_mac_relu_if.slave bus
);

  logic signed [DATA_W-1:0] win [9];
  logic signed [DATA_W-1:0] weight_q [9];
  logic signed [DATA_W-1:0] weight_d [9];
  logic signed [BIAS_W-1:0] bias_q, bias_d;
  logic [3:0]               shift_q, shift_d;
  logic                     relu_q, relu_d;
  logic [9:0]               mask_q, mask_d;
  state_e                   state_q, state_d;
  logic                     s1_valid_q, s1_valid_d;
  logic signed [PROD_W-1:0] prod_q [9];
  logic signed [PROD_W-1:0] prod_d [9];
  logic                     s2_valid_q, s2_valid_d;
  logic signed [ACC_W-1:0]  part_q [3];
  logic signed [ACC_W-1:0]  part_d [3];
  logic [15:0]              cnt_q, cnt_d;
  logic [15:0]              frame_px;
  logic                     frame_done_q, frame_done_d;
  logic                     err_q, err_d;
  logic                     busy, win_acc, win_drop, cfg_rej, cfg_acc, last_px;

  assign win[0] = bus.win0;
  assign win[1] = bus.win1;
  assign win[2] = bus.win2;
  assign win[3] = bus.win3;
  assign win[4] = bus.win4;
  assign win[5] = bus.win5;
  assign win[6] = bus.win6;
  assign win[7] = bus.win7;
  assign win[8] = bus.win8;

  // An accepted window always wins over a simultaneous config write.
  assign busy     = (state_q == RUN) || s1_valid_q || s2_valid_q;
  assign win_acc  = bus.valid_in && (state_q != UNCFG);
  assign win_drop = bus.valid_in && (state_q == UNCFG);
  assign cfg_rej  = bus.cfg_we && (busy || win_acc);
  assign cfg_acc  = bus.cfg_we && !cfg_rej;

  always_comb begin
    weight_d = weight_q;
    bias_d   = bias_q;
    shift_d  = shift_q;
    relu_d   = relu_q;
    mask_d   = mask_q;
    if (cfg_acc) begin
      for (int i = 0; i < 9; i++) begin
        if (bus.cfg_addr == CFG_W0 + 4'(i)) begin
          weight_d[i] = $signed(bus.cfg_data[DATA_W-1:0]);
          mask_d[i]   = 1'b1;
        end
      end
      if (bus.cfg_addr == CFG_BIAS) begin
        bias_d    = $signed(bus.cfg_data[BIAS_W-1:0]);
        mask_d[9] = 1'b1;
      end
      if (bus.cfg_addr == CFG_CTRL) begin
        shift_d = bus.cfg_data[3:0];
        relu_d  = bus.cfg_data[4];
      end
    end
  end

  always_comb begin
    s1_valid_d = win_acc;
    prod_d     = prod_q;
    if (win_acc) begin
      for (int i = 0; i < 9; i++) begin
        prod_d[i] = PROD_W'(win[i]) * PROD_W'(weight_q[i]);
      end
    end
    s2_valid_d = s1_valid_q;
    part_d     = part_q;
    if (s1_valid_q) begin
      for (int r = 0; r < 3; r++) begin
        part_d[r] = ACC_W'(prod_q[3*r]) + ACC_W'(prod_q[3*r+1]) + ACC_W'(prod_q[3*r+2]);
      end
    end
  end

  // The counter advances alongside the S3 register so frame_done lines up with valid_out.
  always_comb begin
    frame_px     = 16'(bus.img_width) * 16'(bus.img_height);
    last_px      = (frame_px != 16'd0) && (cnt_q == frame_px - 16'd1);
    frame_done_d = s2_valid_q && last_px;
    cnt_d        = cnt_q;
    if (s2_valid_q) begin
      cnt_d = last_px ? 16'd0 : cnt_q + 16'd1;
    end
    err_d = cfg_rej || win_drop;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      UNCFG:   if (&mask_q) state_d = READY;
      READY:   if (win_acc) state_d = RUN;
      RUN:     if (frame_done_d && !win_acc) state_d = READY;
      default: state_d = UNCFG;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        weight_q[i] <= '0;
        prod_q[i]   <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        part_q[r] <= '0;
      end
      bias_q       <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      mask_q       <= '0;
      state_q      <= UNCFG;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      weight_q     <= weight_d;
      prod_q       <= prod_d;
      part_q       <= part_d;
      bias_q       <= bias_d;
      shift_q      <= shift_d;
      relu_q       <= relu_d;
      mask_q       <= mask_d;
      state_q      <= state_d;
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  conv_requant u_requant (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (s2_valid_q),
    .part0     (part_q[0]),
    .part1     (part_q[1]),
    .part2     (part_q[2]),
    .bias      (bias_q),
    .shift     (shift_q),
    .relu_en   (relu_q),
    .pix_out   (bus.pix_out),
    .valid_out (bus.valid_out)
  );

  assign bus.frame_done = frame_done_q;
  assign bus.cfg_ready  = (state_q != UNCFG);
  assign bus.err        = err_q;

endmodule

`default_nettype wire

// File: doc/conv3x3_mac_relu.md
Name: conv3x3_mac_relu

Overview:
- Consumes the nine 3x3 window taps and per-window valid from the padded window buffer.
- Computes one signed 8-bit convolution output per window: multiply-accumulate with nine stored weights, add bias, rounding right-shift, optional ReLU, saturate to int8.
- Fixed 3-cycle pipeline with a configuration register file and a per-frame output counter.
- Sits directly downstream of the window buffer and upstream of the pooling / feature-map writeback stage.

Parameters:
- DATA_W, 8, pixel and weight width (signed)
- BIAS_W, 16, bias width (signed)
- ACC_W, 20, accumulator width; must be ≥ 2*DATA_W+4 so that nine products plus bias cannot overflow.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; synchronous, active-high
- cfg_we  in  1  config write strobe
- cfg_addr  in  4  config address: 0-8 = weight w0..w8 (w0 = top-left, row-major); 9 = bias; 10 = ctrl
- cfg_data  in  16  write data: weights use [7:0]; bias uses [15:0]; ctrl uses [3:0] = shift, [4] = relu_en
- img_width  in  8  output pixels per row
- img_height  in  8  output rows per frame
- valid_in  in  1  window taps valid this cycle
- win0..win8  in  8 each  signed window taps, row-major, win4 = centre
- pix_out  out  8  signed convolution result
- valid_out  out  1  pix_out valid
- frame_done  out  1  one-cycle pulse on the last output of a frame
- cfg_ready  out  1  high once weights 0-8 and bias have all been written
- err  out  1  one-cycle pulse on a rejected config write or a dropped window

Behaviour:
- Reset: every output is 0; weights, bias and ctrl are 0; written-mask is cleared; pipeline valids are cleared; frame counter is 0; state is UNCFG. A reset mid-frame discards all in-flight windows, and no valid_out appears afterwards.
- States:
  - UNCFG → READY when the written-mask (addresses 0-9) is complete. Ctrl is optional and defaults to shift 0, relu off.
  - READY → RUN on the first accepted valid_in.
  - RUN → READY on the cycle frame_done is asserted.
- cfg_ready = (state != UNCFG).
- busy = (state == RUN) or any pipeline valid bit is set.
- Config writes:
  - Accepted when !busy; they take effect the next cycle.
  - A write while busy is ignored and pulses err.
  - cfg_addr 11-15 are ignored silently.
- Window input:
  - valid_in in UNCFG drops the window and pulses err.
  - Otherwise the window is accepted every cycle with no backpressure; back-to-back windows are allowed.
  - If cfg_we and valid_in are both asserted while !busy, the window is accepted and the write is rejected (err).
- Pipeline (latency 3: a window accepted in cycle N appears on pix_out in cycle N+3):
  - S1 registers the nine signed products, each 16 bits.
  - S2 registers three row partial sums, each ACC_W bits, sign-extended.
  - S3 forms the sum of the partials plus sign-extended bias.
    - If shift > 0, adds 1 << (shift-1) and then arithmetic-shifts right by shift; shift = 0 applies neither.
    - If relu_en, negative values become 0.
    - Saturates to [-128, 127] and registers pix_out and valid_out.
- pix_out holds its last value when valid_out is 0.
- Frame counter:
  - Increments on each valid_out.
  - When the count equals img_width*img_height-1 with valid_out high, frame_done is asserted in that same cycle and the counter returns to 0.
  - img_width or img_height equal to 0 is a configuration error: outputs are still produced and frame_done never fires.
- img_width and img_height are sampled live and must be held stable while busy.

Decomposition:
- Shared package conv_pkg:
  - DATA_W, BIAS_W, ACC_W
  - cfg address constants: CFG_W0 = 0, CFG_BIAS = 9, CFG_CTRL = 10
  - state enum {UNCFG, READY, RUN}
  - the saturate-to-int8 function
- One sub-module: conv_requant (stage S3: bias add, rounding shift, ReLU, saturation), a registered single-stage block. It is reusable by later layers.

Test Plan:
- Weights all 1, bias 0, ctrl 0; single window with all taps = 2 → pix_out = 18 exactly 3 cycles after valid_in.
- w4 = 1, others 0, bias 0; window centre -5: with relu off → -5; with ctrl = 0x10 → 0.
- Weights all 127, taps all 127 → 127 (saturated high). Taps all -128, relu off → -128 (saturated low). Weights 1, taps 3, bias 0, shift 2 → (27+2)>>2 = 7. Bias -30, same window, shift 0 → -3.
- img 3x2; 6 consecutive valid_in cycles → 6 consecutive valid_out, frame_done high with the 6th only; state returns to READY; a following cfg write is accepted.
- cfg write to w0 during the frame → err pulse and the result is unchanged. valid_in before configuration complete → err pulse and no valid_out.
- rst asserted two cycles into a frame → no valid_out afterwards, all outputs 0, cfg_ready = 0.
